piccolo_dec_keysched: RTL and testbench

PICCOLO_DEC_KEYSCHED -- requirements
Module: piccolo_dec_keysched

---
 rtl/piccolo_dec_keysched.sv | 154 +++++++++++++++
 tb/tb_piccolo_dec_keysched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piccolo_dec_keysched.sv
// Piccolo-80 key schedule streamer, decryption order.
// Registers the key on start, emits the reordered whitening keys once, then
// streams one round-key pair per accepted handshake, last round first. Odd
// decryption rounds carry their pair half-swapped.
// Optional macro PICCOLO_ENC_MODE_EN adds an enc input; with enc=1 the
// forward (encryption) schedule is streamed instead.
module piccolo_dec_keysched #(
    parameter int ROUNDS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key,
`ifdef PICCOLO_ENC_MODE_EN
    input  logic        enc,
`endif
    output logic        busy,
    output logic [63:0] wk_out,
    output logic        wk_valid,
    output logic [31:0] rk_out,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [4:0]  rk_idx,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t      state;
    logic [79:0] key_r;
    logic [4:0]  d;
    logic [4:0]  d_next;
    logic        mode_enc;
    logic [31:0] first_pair;
    logic [31:0] next_pair;
    logic [63:0] wk_calc;

    // Forward pair (rk2i, rk2i+1): round constant XOR the key words picked by i mod 5
    function automatic logic [31:0] fwd_pair(input logic [79:0] k, input logic [4:0] i);
        logic [4:0]  c;
        logic [4:0]  m;
        logic [31:0] con;
        logic [31:0] kw;
        c   = i + 5'd1;
        con = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h0f1e2d3c;
        m   = i % 5'd5;
        case (m)
            5'd0, 5'd2: kw = k[47:16];
            5'd1, 5'd4: kw = k[79:48];
            default:    kw = {k[15:0], k[15:0]};
        endcase
        return con ^ kw;
    endfunction

    // Pair for stream position dd: forward order in enc mode, otherwise
    // reversed rounds with the halves swapped on odd positions
    function automatic logic [31:0] sched_pair(input logic [79:0] k, input logic e,
                                               input logic [4:0] dd);
        logic [31:0] f;
        if (e) begin
            f = fwd_pair(k, dd);
        end else begin
            f = fwd_pair(k, LAST - dd);
            if (dd[0]) f = {f[15:0], f[31:16]};
        end
        return f;
    endfunction

    // Whitening keys, forward order {wk0,wk1,wk2,wk3} or decryption order {wk2,wk3,wk0,wk1}
    function automatic logic [63:0] whiten(input logic [79:0] k, input logic e);
        logic [15:0] w0, w1, w2, w3;
        w0 = {k[79:72], k[55:48]};
        w1 = {k[63:56], k[71:64]};
        w2 = {k[15:8],  k[23:16]};
        w3 = {k[31:24], k[7:0]};
        return e ? {w0, w1, w2, w3} : {w2, w3, w0, w1};
    endfunction

`ifdef PICCOLO_ENC_MODE_EN
    logic enc_r;
    assign mode_enc = enc_r;
`else
    assign mode_enc = 1'b0;
`endif

    assign d_next     = d + 5'd1;
    assign first_pair = sched_pair(key_r, mode_enc, 5'd0);
    assign next_pair  = sched_pair(key_r, mode_enc, d_next);
    assign wk_calc    = whiten(key_r, mode_enc);
    assign rk_idx     = d;

    // Control FSM with registered outputs; reset clears the whole schedule
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            key_r    <= '0;
            d        <= '0;
            busy     <= 1'b0;
            wk_out   <= '0;
            wk_valid <= 1'b0;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
`ifdef PICCOLO_ENC_MODE_EN
            enc_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_r    <= key;
`ifdef PICCOLO_ENC_MODE_EN
                        enc_r    <= enc;
`endif
                        busy     <= 1'b1;
                        wk_valid <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    wk_out   <= wk_calc;
                    wk_valid <= 1'b1;
                    d        <= 5'd0;
                    rk_out   <= first_pair;
                    rk_valid <= 1'b1;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (rk_ready) begin
                        if (d == LAST) begin
                            // counter parks at the last round; never wraps
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            d      <= d_next;
                            rk_out <= next_pair;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo_dec_keysched.sv
// Scoreboard bench for piccolo_dec_keysched: expected pairs are queued when a
// schedule is requested and popped on every rk handshake.
module tb_piccolo_dec_keysched;

    localparam int ROUNDS = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic        busy;
    logic [63:0] wk_out;
    logic        wk_valid;
    logic [31:0] rk_out;
    logic        rk_valid;
    logic        rk_ready;
    logic [4:0]  rk_idx;
    logic        done;
`ifdef PICCOLO_ENC_MODE_EN
    logic        enc;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] pair;
    } exp_t;

    exp_t        q[$];
    logic [31:0] obs[32];
    logic [63:0] wk_seen;

    piccolo_dec_keysched #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
`ifdef PICCOLO_ENC_MODE_EN
        .enc      (enc),
`endif
        .busy     (busy),
        .wk_out   (wk_out),
        .wk_valid (wk_valid),
        .rk_out   (rk_out),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_fwd(input logic [79:0] k, input int i);
        logic [15:0] ks[5];
        logic [4:0]  c;
        logic [31:0] con;
        logic [15:0] a, b;
        for (int j = 0; j < 5; j++) ks[j] = k[79-16*j -: 16];
        c   = 5'(i + 1);
        con = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h0f1e2d3c;
        case (i % 5)
            0, 2:    begin a = ks[2]; b = ks[3]; end
            1, 4:    begin a = ks[0]; b = ks[1]; end
            default: begin a = ks[4]; b = ks[4]; end
        endcase
        return con ^ {a, b};
    endfunction

    function automatic logic [31:0] model_dec(input logic [79:0] k, input logic e, input int d);
        logic [31:0] f;
        if (e) return model_fwd(k, d);
        f = model_fwd(k, ROUNDS - 1 - d);
        return (d % 2 == 1) ? {f[15:0], f[31:16]} : f;
    endfunction

    function automatic logic [63:0] model_wk(input logic [79:0] k, input logic e);
        logic [15:0] k0, k1, k3, k4;
        logic [15:0] w0, w1, w2, w3;
        k0 = k[79:64]; k1 = k[63:48]; k3 = k[31:16]; k4 = k[15:0];
        w0 = {k0[15:8], k1[7:0]};
        w1 = {k1[15:8], k0[7:0]};
        w2 = {k4[15:8], k3[7:0]};
        w3 = {k3[15:8], k4[7:0]};
        return e ? {w0, w1, w2, w3} : {w2, w3, w0, w1};
    endfunction

    // Drive one full schedule and check every transfer against the scoreboard.
    task automatic run_stream(input logic [79:0] k, input logic e, input int stall_at,
                              input int stall_len, input bit rnd, input bit noise);
        int          stalled = 0;
        int          n = 0;
        bit          hold = 0;
        bit          fin = 0;
        bit          abort = 0;
        logic [31:0] h_out = '0;
        logic [4:0]  h_idx = '0;
        exp_t        x;
        q.delete();
        for (int dd = 0; dd < ROUNDS; dd++) q.push_back({5'(dd), model_dec(k, e, dd)});
        @(negedge clk);
        key = k; start = 1'b1; rk_ready = 1'b1;
`ifdef PICCOLO_ENC_MODE_EN
        enc = e;
`endif
        @(negedge clk);
        start = noise; key = ~k;
`ifdef PICCOLO_ENC_MODE_EN
        enc = ~e;
`endif
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL load_state rk_valid=%b busy=%b required 0/1", rk_valid, busy);
        if (rk_valid !== 1'b0 || busy !== 1'b1) errors++;
        @(negedge clk);
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 5'd0 || wk_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_latency rk_valid=%b rk_idx=%0d wk_valid=%b required 1/0/1",
                     rk_valid, rk_idx, wk_valid);
        end
        wk_seen = wk_out;
        checks++;
        if (wk_out !== model_wk(k, e)) begin
            errors++;
            $display("FAIL wk got %h required %h", wk_out, model_wk(k, e));
        end
        for (int cyc = 0; cyc < 400 && !fin && !abort; cyc++) begin
            logic rdy;
            if (rnd) rdy = 1'($urandom_range(0, 1));
            else if (rk_idx == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else rdy = 1'b1;
            rk_ready = rdy;
            if (hold) begin
                checks++;
                if (rk_out !== h_out || rk_idx !== h_idx) begin
                    errors++;
                    $display("FAIL hold got %0d:%h required %0d:%h", rk_idx, rk_out, h_idx, h_out);
                end
            end
            checks++;
            if (rk_valid !== 1'b1) begin
                errors++;
                abort = 1;
                $display("FAIL valid_drop rk_valid=%b required 1 at transfer %0d", rk_valid, n);
            end else if (rdy) begin
                if (q.size() == 0) begin
                    errors++;
                    abort = 1;
                    $display("FAIL extra_transfer idx=%0d required none", rk_idx);
                end else begin
                    x = q.pop_front();
                    if ({rk_idx, rk_out} !== {x.idx, x.pair}) begin
                        errors++;
                        $display("FAIL pair got %0d:%h required %0d:%h", rk_idx, rk_out, x.idx, x.pair);
                    end
                    obs[rk_idx] = rk_out;
                    n++;
                    if (q.size() == 0) begin
                        fin = 1;
                        start = 1'b0;
                    end
                end
            end
            hold  = rk_valid && !rdy;
            h_out = rk_out;
            h_idx = rk_idx;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL stream_end transfers=%0d required %0d", n, ROUNDS);
        end else begin
            if (done !== 1'b1 || busy !== 1'b1 || rk_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse done=%b busy=%b rk_valid=%b required 1/1/0",
                         done, busy, rk_valid);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || wk_valid !== 1'b1) begin
                errors++;
                $display("FAIL after_done done=%b busy=%b wk_valid=%b required 0/0/1",
                         done, busy, wk_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, wk_valid, rk_valid, done, wk_out, rk_out, rk_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b wk=%h rk=%h idx=%0d done=%b required all 0",
                     busy, wk_out, rk_out, rk_idx, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, wk_valid, rk_valid, done, rk_idx} !== '0) begin
            errors++;
            $display("FAIL idle_outputs busy=%b rk_valid=%b done=%b required 0", busy, rk_valid, done);
        end
    endtask

    task automatic test_basic();
        run_stream(80'h00112233445566778899, 1'b0, -1, 0, 1'b0, 1'b0);
        checks++;
        if (wk_seen !== 64'h8877_6699_0033_2211) begin
            errors++;
            $display("FAIL basic_wk got %h required 8877669900332211", wk_seen);
        end
        checks++;
        if (obs[0] !== 32'hC73D6B16) begin
            errors++;
            $display("FAIL basic_first got %h required C73D6B16", obs[0]);
        end
        checks++;
        if (obs[24] !== 32'h43494F4A) begin
            errors++;
            $display("FAIL basic_last got %h required 43494F4A", obs[24]);
        end
    endtask

    task automatic test_swap();
        logic [31:0] f;
        f = model_fwd(80'h00112233445566778899, 23);
        checks++;
        if (obs[1] !== 32'hC5BD47B7 || obs[1] !== {f[15:0], f[31:16]}) begin
            errors++;
            $display("FAIL swap_d1 got %h required C5BD47B7", obs[1]);
        end
    endtask

    task automatic test_backpressure();
        run_stream(80'h00112233445566778899, 1'b0, 3, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        @(negedge clk);
        key = 80'h0123456789abcdef0123; start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (rk_valid === 1'b1 && rk_idx == 5'd10) hit = 1;
            else @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!hit || {busy, wk_valid, rk_valid, done, wk_out, rk_out, rk_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid hit=%b busy=%b rk_valid=%b rk=%h idx=%0d required 0",
                     hit, busy, rk_valid, rk_out, rk_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        run_stream(80'h0123456789abcdef0123, 1'b0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [95:0] r;
        for (int t = 0; t < 3; t++) begin
            r = {$urandom, $urandom, $urandom};
            run_stream(r[79:0], 1'b0, -1, 0, 1'b1, 1'b1);
        end
    endtask

`ifdef PICCOLO_ENC_MODE_EN
    task automatic test_enc();
        run_stream(80'h00112233445566778899, 1'b1, 7, 3, 1'b0, 1'b0);
        checks++;
        if (wk_seen !== 64'h0033_2211_8877_6699 || obs[0] !== 32'h43494F4A ||
            obs[24] !== 32'hC73D6B16) begin
            errors++;
            $display("FAIL enc_vectors wk=%h first=%h last=%h required 0033221188776699/43494F4A/C73D6B16",
                     wk_seen, obs[0], obs[24]);
        end
        run_stream(80'h00112233445566778899, 1'b0, -1, 0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
`ifdef PICCOLO_ENC_MODE_EN
        enc = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_swap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef PICCOLO_ENC_MODE_EN
        test_enc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d required completion", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
